gpu_cmd_queue: RTL and testbench

- Command FIFO and sequencer sitting directly upstream of the gpu control interface.
- Accepts draw/clear commands from the CPU bus bridge via a valid/ready handshake and buffers up to DEPTH of them.
- Issues one command at a time to the gpu as a registered rising-edge strobe (ctrl_draw / ctrl_clear).
- Holds all ctrl_* fields stable for the whole operation, because the gpu samples them continuously while busy.

---
 rtl/gpu_pkg.sv | 38 +++
 rtl/gpu_cmd_fifo.sv | 69 ++++++
 rtl/gpu_cmd_queue.sv | 175 +++++++++++++++++
 tb/tb_gpu_cmd_queue.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared types and constants for the gpu command queue and its FIFO.
package gpu_pkg;

    localparam int FB_WIDTH_DEF  = 400;
    localparam int FB_HEIGHT_DEF = 240;
    localparam int CMD_XW        = $clog2(FB_WIDTH_DEF) + 2;
    localparam int CMD_YW        = $clog2(FB_HEIGHT_DEF) + 2;

    localparam logic OP_DRAW  = 1'b0;
    localparam logic OP_CLEAR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_e;

    // Everything the gpu samples while busy; the opcode travels alongside it.
    typedef struct packed {
        logic [31:0]       address;
        logic [15:0]       address_x;
        logic [15:0]       address_y;
        logic [15:0]       image_width;
        logic [CMD_XW-1:0] width;
        logic [CMD_YW-1:0] height;
        logic [CMD_XW-1:0] x;
        logic [CMD_YW-1:0] y;
        logic [15:0]       clear_color;
    } cmd_fields_t;

    typedef struct packed {
        logic        op;
        cmd_fields_t f;
    } cmd_entry_t;

    localparam int ENTRY_W = $bits(cmd_entry_t);

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Generic synchronous FIFO with registered occupancy count; DEPTH must be a power of two.
module gpu_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/gpu_cmd_queue.sv
// Buffers draw/clear commands and issues them one at a time to the gpu control port.
//   state    | meaning
//   ST_IDLE  | no command outstanding; pops head when gpu is free
//   ST_ISSUE | strobe high, waiting for gpu_busy or timeout
//   ST_BUSY  | strobe low, waiting for gpu_busy to fall
module gpu_cmd_queue
    import gpu_pkg::*;
#(
    parameter int FB_WIDTH      = FB_WIDTH_DEF,
    parameter int FB_HEIGHT     = FB_HEIGHT_DEF,
    parameter int DEPTH         = 8,
    parameter int ISSUE_TIMEOUT = 15,
    localparam int XW = $clog2(FB_WIDTH) + 2,
    localparam int YW = $clog2(FB_HEIGHT) + 2,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [31:0]   cmd_address,
    input  logic [15:0]   cmd_address_x,
    input  logic [15:0]   cmd_address_y,
    input  logic [15:0]   cmd_image_width,
    input  logic [XW-1:0] cmd_width,
    input  logic [YW-1:0] cmd_height,
    input  logic [XW-1:0] cmd_x,
    input  logic [YW-1:0] cmd_y,
    input  logic [15:0]   cmd_clear_color,
    output logic [31:0]   ctrl_address,
    output logic [15:0]   ctrl_address_x,
    output logic [15:0]   ctrl_address_y,
    output logic [15:0]   ctrl_image_width,
    output logic [XW-1:0] ctrl_width,
    output logic [YW-1:0] ctrl_height,
    output logic [XW-1:0] ctrl_x,
    output logic [YW-1:0] ctrl_y,
    output logic [15:0]   ctrl_clear_color,
    output logic          ctrl_draw,
    output logic          ctrl_clear,
    input  logic          gpu_busy,
    output logic [CW-1:0] queue_count,
    output logic          queue_idle,
    output logic          timeout_err
);

    localparam int TW = $clog2(ISSUE_TIMEOUT + 1);

    cmd_entry_t         push_entry;
    cmd_entry_t         head_entry;
    logic [ENTRY_W-1:0] head_raw;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;

    state_e             state_q, state_d;
    logic [TW-1:0]      tmr_q, tmr_d;
    cmd_fields_t        fields_q, fields_d;
    logic               draw_q, draw_d;
    logic               clear_q, clear_d;
    logic               err_q, err_d;

    always_comb begin
        push_entry               = '0;
        push_entry.op            = cmd_op;
        push_entry.f.address     = cmd_address;
        push_entry.f.address_x   = cmd_address_x;
        push_entry.f.address_y   = cmd_address_y;
        push_entry.f.image_width = cmd_image_width;
        push_entry.f.width       = cmd_width;
        push_entry.f.height      = cmd_height;
        push_entry.f.x           = cmd_x;
        push_entry.f.y           = cmd_y;
        push_entry.f.clear_color = cmd_clear_color;
    end

    gpu_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_valid),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head_raw),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (queue_count)
    );

    assign head_entry = cmd_entry_t'(head_raw);
    assign cmd_ready  = !fifo_full;

    // Issue timer counts down from ISSUE_TIMEOUT-1; terminal count aborts the issue.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        fields_d = fields_q;
        draw_d   = draw_q;
        clear_d  = clear_q;
        err_d    = err_q;
        pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !gpu_busy) begin
                    pop      = 1'b1;
                    fields_d = head_entry.f;
                    draw_d   = (head_entry.op == OP_DRAW);
                    clear_d  = (head_entry.op == OP_CLEAR);
                    tmr_d    = TW'(ISSUE_TIMEOUT - 1);
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (gpu_busy) begin
                    draw_d  = 1'b0;
                    clear_d = 1'b0;
                    state_d = ST_BUSY;
                end else if (tmr_q == '0) begin
                    draw_d  = 1'b0;
                    clear_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            ST_BUSY: begin
                if (!gpu_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                draw_d  = 1'b0;
                clear_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            fields_q <= '0;
            draw_q   <= 1'b0;
            clear_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            fields_q <= fields_d;
            draw_q   <= draw_d;
            clear_q  <= clear_d;
            err_q    <= err_d;
        end
    end

    assign ctrl_address     = fields_q.address;
    assign ctrl_address_x   = fields_q.address_x;
    assign ctrl_address_y   = fields_q.address_y;
    assign ctrl_image_width = fields_q.image_width;
    assign ctrl_width       = fields_q.width;
    assign ctrl_height      = fields_q.height;
    assign ctrl_x           = fields_q.x;
    assign ctrl_y           = fields_q.y;
    assign ctrl_clear_color = fields_q.clear_color;
    assign ctrl_draw        = draw_q;
    assign ctrl_clear       = clear_q;
    assign timeout_err      = err_q;
    assign queue_idle       = fifo_empty && (state_q == ST_IDLE) && !gpu_busy;

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Randomised bench for gpu_cmd_queue with a transaction-level reference model and gpu responder.
module tb_gpu_cmd_queue;

    localparam int DEPTH = 8;
    localparam int TMO   = 15;
    localparam int XW    = $clog2(400) + 2;
    localparam int YW    = $clog2(240) + 2;

    typedef struct packed {
        logic          op;
        logic [31:0]   address;
        logic [15:0]   ax;
        logic [15:0]   ay;
        logic [15:0]   iw;
        logic [XW-1:0] w;
        logic [YW-1:0] h;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [15:0]   color;
    } ent_t;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [31:0]   cmd_address;
    logic [15:0]   cmd_address_x;
    logic [15:0]   cmd_address_y;
    logic [15:0]   cmd_image_width;
    logic [XW-1:0] cmd_width;
    logic [YW-1:0] cmd_height;
    logic [XW-1:0] cmd_x;
    logic [YW-1:0] cmd_y;
    logic [15:0]   cmd_clear_color;
    logic [31:0]   ctrl_address;
    logic [15:0]   ctrl_address_x;
    logic [15:0]   ctrl_address_y;
    logic [15:0]   ctrl_image_width;
    logic [XW-1:0] ctrl_width;
    logic [YW-1:0] ctrl_height;
    logic [XW-1:0] ctrl_x;
    logic [YW-1:0] ctrl_y;
    logic [15:0]   ctrl_clear_color;
    logic          ctrl_draw;
    logic          ctrl_clear;
    logic          gpu_busy;
    logic [3:0]    queue_count;
    logic          queue_idle;
    logic          timeout_err;

    gpu_cmd_queue #(
        .DEPTH         (DEPTH),
        .ISSUE_TIMEOUT (TMO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_address      (cmd_address),
        .cmd_address_x    (cmd_address_x),
        .cmd_address_y    (cmd_address_y),
        .cmd_image_width  (cmd_image_width),
        .cmd_width        (cmd_width),
        .cmd_height       (cmd_height),
        .cmd_x            (cmd_x),
        .cmd_y            (cmd_y),
        .cmd_clear_color  (cmd_clear_color),
        .ctrl_address     (ctrl_address),
        .ctrl_address_x   (ctrl_address_x),
        .ctrl_address_y   (ctrl_address_y),
        .ctrl_image_width (ctrl_image_width),
        .ctrl_width       (ctrl_width),
        .ctrl_height      (ctrl_height),
        .ctrl_x           (ctrl_x),
        .ctrl_y           (ctrl_y),
        .ctrl_clear_color (ctrl_clear_color),
        .ctrl_draw        (ctrl_draw),
        .ctrl_clear       (ctrl_clear),
        .gpu_busy         (gpu_busy),
        .queue_count      (queue_count),
        .queue_idle       (queue_idle),
        .timeout_err      (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [159:0] fields_of(input ent_t e);
        return 160'({e.address, e.ax, e.ay, e.iw, e.w, e.h, e.x, e.y, e.color});
    endfunction

    function automatic ent_t rand_ent();
        ent_t e;
        e.op      = 1'($urandom_range(0, 1));
        e.address = $urandom;
        e.ax      = 16'($urandom);
        e.ay      = 16'($urandom);
        e.iw      = 16'($urandom);
        e.w       = XW'($urandom);
        e.h       = YW'($urandom);
        e.x       = XW'($urandom);
        e.y       = YW'($urandom);
        e.color   = 16'($urandom);
        return e;
    endfunction

    // ---------------- gpu responder ----------------
    int gmode    = 0;   // 0 responsive, 1 never busy, 2 held busy
    int busy_len = 0;   // 0 picks a random length per command
    int g_len    = 0;
    int g_dly    = 0;
    bit g_forced = 0;

    always @(negedge clk) begin
        if (gmode != 0) begin
            gpu_busy = (gmode == 2);
            g_forced = 1'b1;
            g_len    = 0;
            g_dly    = 0;
        end else if (g_forced) begin
            gpu_busy = 1'b0;
            g_forced = 1'b0;
        end else if (g_len > 0) begin
            g_len--;
            if (g_len == 0) gpu_busy = 1'b0;
        end else if (g_dly > 0) begin
            g_dly--;
            if (g_dly == 0) begin
                gpu_busy = 1'b1;
                g_len    = (busy_len > 0) ? busy_len : $urandom_range(1, 6);
            end
        end else if ((ctrl_draw || ctrl_clear) && !gpu_busy) begin
            g_dly = $urandom_range(0, 2);
            if (g_dly == 0) begin
                gpu_busy = 1'b1;
                g_len    = (busy_len > 0) ? busy_len : $urandom_range(1, 6);
            end
        end
    end

    // ---------------- reference model and monitor ----------------
    ent_t        mq[$];
    ent_t        m_cur;
    ent_t        in_e;
    bit          m_str, m_wait, m_err, do_push;
    int          m_age;
    bit          rise_ops[$];
    logic [15:0] rise_col[$];
    bit          strobe_prev, strobe_now, seen_rise;
    int          gap, min_gap;

    initial begin
        m_cur = '0; m_str = 0; m_wait = 0; m_err = 0; m_age = 0;
        strobe_prev = 0; seen_rise = 0; gap = 0; min_gap = 1000;
    end

    always @(posedge clk) begin
        in_e = '{cmd_op, cmd_address, cmd_address_x, cmd_address_y, cmd_image_width,
                 cmd_width, cmd_height, cmd_x, cmd_y, cmd_clear_color};
        do_push = cmd_valid && (mq.size() < DEPTH);
        if (reset) begin
            mq.delete();
            m_cur = '0; m_str = 0; m_wait = 0; m_err = 0; m_age = 0;
        end else begin
            if (m_str) begin
                if (gpu_busy) begin
                    m_str = 0; m_wait = 1;
                end else if (m_age == TMO) begin
                    m_str = 0; m_err = 1;
                end else begin
                    m_age++;
                end
            end else if (m_wait) begin
                if (!gpu_busy) m_wait = 0;
            end else if (mq.size() > 0 && !gpu_busy) begin
                m_cur = mq.pop_front();
                m_str = 1;
                m_age = 1;
            end
            if (do_push) mq.push_back(in_e);
        end
        #1;
        chk_eq("draw", 160'(ctrl_draw), 160'(m_str && m_cur.op == 1'b0));
        chk_eq("clear", 160'(ctrl_clear), 160'(m_str && m_cur.op == 1'b1));
        chk_eq("fields", 160'({ctrl_address, ctrl_address_x, ctrl_address_y, ctrl_image_width,
                               ctrl_width, ctrl_height, ctrl_x, ctrl_y, ctrl_clear_color}),
               fields_of(m_cur));
        chk_eq("count", 160'(queue_count), 160'(mq.size()));
        chk_eq("ready", 160'(cmd_ready), 160'(mq.size() < DEPTH));
        chk_eq("idle", 160'(queue_idle), 160'(mq.size() == 0 && !m_str && !m_wait && !gpu_busy));
        chk_eq("terr", 160'(timeout_err), 160'(m_err));
        strobe_now = ctrl_draw || ctrl_clear;
        if (strobe_now && !strobe_prev) begin
            rise_ops.push_back(ctrl_clear);
            rise_col.push_back(ctrl_clear_color);
            if (seen_rise && gap < min_gap) min_gap = gap;
            seen_rise = 1;
            gap = 0;
        end else if (!strobe_now) begin
            gap++;
        end
        strobe_prev = strobe_now;
    end

    task automatic log_clear();
        rise_ops.delete();
        rise_col.delete();
        seen_rise = 0;
        min_gap   = 1000;
        gap       = 0;
    endtask

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic drive(input ent_t e);
        cmd_op = e.op; cmd_address = e.address; cmd_address_x = e.ax; cmd_address_y = e.ay;
        cmd_image_width = e.iw; cmd_width = e.w; cmd_height = e.h; cmd_x = e.x; cmd_y = e.y;
        cmd_clear_color = e.color;
    endtask

    task automatic push_cmd(input ent_t e);
        int n = 0;
        drive(e);
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk_eq("push_timeout", 160'(0), 160'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        @(negedge clk);
        while (!queue_idle && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxc) chk_eq("idle_timeout", 160'(0), 160'(1));
    endtask

    task automatic set_mode(input int m);
        @(posedge clk);
        #2 gmode = m;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ent_t e;
        int   n;
        reset = 1'b1; cmd_valid = 1'b0; gpu_busy = 1'b0;
        drive('0);
        repeat (3) @(negedge clk);
        chk_eq("rst_ready", 160'(cmd_ready), 160'(1));
        chk_eq("rst_idle", 160'(queue_idle), 160'(1));
        chk_eq("rst_count", 160'(queue_count), 160'(0));
        chk_eq("rst_strobe", 160'({ctrl_draw, ctrl_clear}), 160'(0));
        reset = 1'b0;
        @(negedge clk);

        // single draw with a long busy period
        busy_len = 128;
        log_clear();
        e = '0; e.op = 1'b0; e.address = 32'h1000; e.w = 16; e.h = 8; e.x = 10; e.y = 20;
        push_cmd(e);
        chk_eq("t1_before", 160'(ctrl_draw), 160'(0));
        @(negedge clk);
        chk_eq("t1_draw", 160'(ctrl_draw), 160'(1));
        chk_eq("t1_addr", 160'(ctrl_address), 160'(32'h1000));
        wait_idle(400);
        chk_eq("t1_idle", 160'(queue_idle), 160'(1));
        chk_eq("t1_hold", 160'({ctrl_width, ctrl_height, ctrl_x, ctrl_y}), 160'({11'd16, 10'd8, 11'd10, 10'd20}));
        chk_eq("t1_rises", 160'(rise_ops.size()), 160'(1));

        // clear then draw back to back
        busy_len = 5;
        log_clear();
        e = rand_ent(); e.op = 1'b1; e.color = 16'h0001;
        push_cmd(e);
        e = rand_ent(); e.op = 1'b0;
        push_cmd(e);
        wait_idle(200);
        chk_eq("t2_rises", 160'(rise_ops.size()), 160'(2));
        if (rise_ops.size() >= 2) begin
            chk_eq("t2_first_clear", 160'(rise_ops[0]), 160'(1));
            chk_eq("t2_second_draw", 160'(rise_ops[1]), 160'(0));
            chk_eq("t2_color", 160'(rise_col[0]), 160'(16'h0001));
        end
        chk_eq("t2_gap", 160'(min_gap >= 1), 160'(1));

        // fill the queue while the gpu is held busy
        busy_len = 0;
        log_clear();
        set_mode(2);
        for (int i = 0; i < 8; i++) push_cmd(rand_ent());
        chk_eq("t3_full_ready", 160'(cmd_ready), 160'(0));
        chk_eq("t3_full_count", 160'(queue_count), 160'(8));
        fork
            push_cmd(rand_ent());
            begin
                repeat (4) @(negedge clk);
                chk_eq("t3_ninth_held", 160'(queue_count), 160'(8));
                @(posedge clk);
                #2 gmode = 0;
            end
        join
        wait_idle(1000);
        chk_eq("t3_rises", 160'(rise_ops.size()), 160'(9));

        // issue timeout, then a normal command
        log_clear();
        set_mode(1);
        push_cmd(rand_ent());
        n = 0;
        while (!(ctrl_draw || ctrl_clear) && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while ((ctrl_draw || ctrl_clear) && n < 40) begin @(negedge clk); n++; end
        chk_eq("t4_strobe_len", 160'(n), 160'(TMO));
        chk_eq("t4_err", 160'(timeout_err), 160'(1));
        set_mode(0);
        push_cmd(rand_ent());
        wait_idle(200);
        chk_eq("t4_err_sticky", 160'(timeout_err), 160'(1));
        chk_eq("t4_rises", 160'(rise_ops.size()), 160'(2));

        // reset while the gpu is busy with queued work behind it
        busy_len = 30;
        for (int i = 0; i < 3; i++) push_cmd(rand_ent());
        n = 0;
        while (!gpu_busy && n < 60) begin @(negedge clk); n++; end
        chk_eq("t5_busy_seen", 160'(gpu_busy), 160'(1));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_eq("t5_strobe", 160'({ctrl_draw, ctrl_clear}), 160'(0));
        chk_eq("t5_count", 160'(queue_count), 160'(0));
        chk_eq("t5_ready", 160'(cmd_ready), 160'(1));
        chk_eq("t5_err", 160'(timeout_err), 160'(0));
        log_clear();
        repeat (60) @(negedge clk);
        chk_eq("t5_no_rises", 160'(rise_ops.size()), 160'(0));

        // simultaneous push and pop at count 4
        busy_len = 0;
        log_clear();
        set_mode(2);
        for (int i = 0; i < 4; i++) push_cmd(rand_ent());
        chk_eq("t6_count4", 160'(queue_count), 160'(4));
        @(posedge clk);
        #2 gmode = 0;
        @(negedge clk);
        drive(rand_ent());
        cmd_valid = 1'b1;
        @(posedge clk);
        #2;
        chk_eq("t6_count_same", 160'(queue_count), 160'(4));
        chk_eq("t6_strobe", 160'(ctrl_draw || ctrl_clear), 160'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle(500);
        chk_eq("t6_rises", 160'(rise_ops.size()), 160'(5));

        // random soak
        log_clear();
        for (int i = 0; i < 60; i++) begin
            push_cmd(rand_ent());
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle(3000);
        chk_eq("soak_rises", 160'(rise_ops.size()), 160'(60));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
